// File: rtl/fetch_frontend.sv
// Purpose: sequential instruction fetch with several reads in flight, buffering {pc, instr} for decode.
// Latency: a response captured at edge t is presented on dec_* after edge t (no bypass into decode).
// Backpressure: reads issue only while FIFO + in-flight + drop credits < DEPTH; responses are never stalled.
module fetch_frontend #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   mem_req_valid,
    output logic [XLEN-1:0]        mem_req_addr,
    input  logic                   mem_req_accept,
    input  logic                   mem_rsp_valid,
    input  logic [XLEN-1:0]        mem_rsp_addr,
    input  logic [XLEN-1:0]        mem_rsp_data,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [XLEN-1:0]        dec_pc,
    output logic [XLEN-1:0]        dec_instr,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [$clog2(DEPTH):0] inflight
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Wide enough that the sum of three counters cannot wrap.
    localparam int SW = CW + 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   occ_q;
    logic [CW-1:0]   infl_q;
    logic [CW-1:0]   drop_q;
    logic [XLEN-1:0] fetch_pc;

    logic [CW-1:0]   occ_n;
    logic [CW-1:0]   infl_n;
    logic [CW-1:0]   drop_n;
    logic [XLEN-1:0] pc_n;
    logic [SW-1:0]   credit_used;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_live;
    logic            push;
    logic            pop;

    // Low address bits of a redirect target are forced to zero and never read.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign credit_used   = SW'(occ_q) + SW'(infl_q) + SW'(drop_q);
    assign mem_req_valid = ~rst & ~hold & ~redirect_valid & (credit_used < SW'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid & mem_req_accept;

    // Stale responses are consumed first; a response with no credit at all is ignored.
    assign rsp_drop = mem_rsp_valid & (drop_q != '0);
    assign rsp_live = mem_rsp_valid & (drop_q == '0) & (infl_q != '0);
    assign push     = rsp_live;

    assign dec_valid = (occ_q != '0) & ~hold;
    assign pop       = dec_valid & dec_ready;
    assign dec_pc    = fifo_mem[rd_ptr].pc;
    assign dec_instr = fifo_mem[rd_ptr].instr;
    assign occupancy = occ_q;
    assign inflight  = infl_q;

    // Next-state for fetch PC and the three credit counters; redirect flushes and converts in-flight to drop.
    always_comb begin
        occ_n  = occ_q;
        infl_n = infl_q;
        drop_n = drop_q;
        pc_n   = fetch_pc;
        if (redirect_valid) begin
            occ_n  = '0;
            infl_n = '0;
            drop_n = drop_q + infl_q - CW'(rsp_drop | rsp_live);
            pc_n   = {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (req_fire) begin
                pc_n = fetch_pc + XLEN'(4);
            end
            infl_n = infl_q + CW'(req_fire) - CW'(rsp_live);
            drop_n = drop_q - CW'(rsp_drop);
            occ_n  = occ_q + CW'(push) - CW'(pop);
        end
    end

    // Control state: counters, pointers and fetch PC; reset and redirect both empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_VECTOR;
            occ_q    <= '0;
            infl_q   <= '0;
            drop_q   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            fetch_pc <= pc_n;
            occ_q    <= occ_n;
            infl_q   <= infl_n;
            drop_q   <= drop_n;
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // FIFO storage; a push in a reset or redirect cycle is discarded with the rest of the contents.
    always_ff @(posedge clk) begin
        if (push && !rst && !redirect_valid) begin
            fifo_mem[wr_ptr] <= '{pc: mem_rsp_addr, instr: mem_rsp_data};
        end
    end

    rsp_without_credit: assert property (@(posedge clk) disable iff (rst)
        mem_rsp_valid |-> (drop_q != '0 || infl_q != '0));

    counters_bounded: assert property (@(posedge clk) disable iff (rst)
        (occ_q <= CW'(DEPTH)) && (infl_q <= CW'(DEPTH)) && (drop_q <= CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_frontend.sv
// Directed bench for fetch_frontend with an in-order memory model of configurable latency.
// Expected decode words are queued as each step is set up and popped when decode consumes a head.
// A second instance with a high reset vector checks fetch address wrap-around.
module tb_fetch_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_accept = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_addr = '0;
    logic [31:0] mem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [2:0]  occupancy;
    logic [2:0]  inflight;

    // Second instance: always-accepting 1-cycle memory, decode always ready.
    logic        h_req_valid;
    logic [31:0] h_req_addr;
    logic        h_rsp_valid = 1'b0;
    logic [31:0] h_rsp_addr = '0;
    logic [31:0] h_rsp_data = '0;
    logic        h_dec_valid;
    logic [31:0] h_dec_pc;
    logic [31:0] h_dec_instr;
    logic [2:0]  h_occ;
    logic [2:0]  h_infl;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    exp_t        exp_q [$];
    exp_t        e;
    mreq_t       mq [$];
    logic [31:0] issued [$];
    logic [31:0] h_issued [$];
    int          pop_cyc [$];
    int          lat = 1;
    int          mcyc = 0;
    int          mon_cyc = 0;
    logic        h_fire;
    logic [31:0] h_addr_s;

    always #5 clk = ~clk;

    fetch_frontend #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'h0)) u_dut (
        .clk(clk), .rst(rst), .hold(hold),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_accept(mem_req_accept),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_addr(mem_rsp_addr), .mem_rsp_data(mem_rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .occupancy(occupancy), .inflight(inflight)
    );

    fetch_frontend #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'hFFFF_FFF8)) u_dut_hi (
        .clk(clk), .rst(rst), .hold(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .mem_req_valid(h_req_valid), .mem_req_addr(h_req_addr), .mem_req_accept(1'b1),
        .mem_rsp_valid(h_rsp_valid), .mem_rsp_addr(h_rsp_addr), .mem_rsp_data(h_rsp_data),
        .dec_valid(h_dec_valid), .dec_ready(1'b1), .dec_pc(h_dec_pc), .dec_instr(h_dec_instr),
        .occupancy(h_occ), .inflight(h_infl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // In-order memory returning data = address after lat cycles; cleared by reset.
    always @(posedge clk) begin
        mcyc++;
        if (rst) begin
            mq.delete();
        end else if (mem_req_valid && mem_req_accept) begin
            mq.push_back('{mcyc + lat - 1, mem_req_addr});
            issued.push_back(mem_req_addr);
        end
        #1;
        if (mq.size() != 0 && mq[0].due <= mcyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_addr  = mq[0].addr;
            mem_rsp_data  = mq[0].addr;
            mq.delete(0);
        end else begin
            mem_rsp_valid = 1'b0;
        end
    end

    // One-cycle memory for the high-reset-vector instance.
    always @(posedge clk) begin
        h_fire   = h_req_valid && !rst;
        h_addr_s = h_req_addr;
        if (h_fire) h_issued.push_back(h_req_addr);
        #1;
        h_rsp_valid = h_fire;
        h_rsp_addr  = h_addr_s;
        h_rsp_data  = h_addr_s;
    end

    // Scoreboard: every decode handshake must match the oldest expected word.
    always @(posedge clk) begin
        mon_cyc++;
        if (!rst && !redirect_valid && dec_valid && dec_ready) begin
            chk("sb_expected_word", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dec_pc", dec_pc, e.pc);
                chk("dec_instr", dec_instr, e.instr);
                pop_cyc.push_back(mon_cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back({a, a});
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_logs();
        exp_q.delete();
        issued.delete();
        h_issued.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset();
        dec_ready      = 1'b0;
        hold           = 1'b0;
        redirect_valid = 1'b0;
        mem_req_accept = 1'b0;
        lat            = 1;
        rst            = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        // Reset state
        settle();
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        rst = 1'b0;
        clear_logs();
        settle();
        chk("post_rst_req_valid", 32'(mem_req_valid), 32'd1);

        // 1: free-running fetch, 1-cycle memory
        do_reset();
        mem_req_accept = 1'b1;
        dec_ready      = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
        drain("t1_drain", 40);
        dec_ready = 1'b0;
        chk("t1_pops", 32'(pop_cyc.size()), 32'd8);
        if (pop_cyc.size() == 8) chk("t1_no_gaps", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

        // 2: decode stalled, credit limit reached
        do_reset();
        mem_req_accept = 1'b1;
        repeat (10) tick();
        settle();
        chk("t2_issued_n", 32'(issued.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_issued_addr", issued[i], 32'(i * 4));
        chk("t2_req_valid", 32'(mem_req_valid), 32'd0);
        chk("t2_occupancy", 32'(occupancy), 32'd4);
        chk("t2_inflight", 32'(inflight), 32'd0);
        issued.delete();
        for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
        dec_ready = 1'b1;
        drain("t2_drain", 30);
        dec_ready = 1'b0;
        chk("t2_resume_n", 32'(issued.size() >= 1), 32'd1);
        chk("t2_resume_addr", issued[0], 32'h10);

        // 3: redirect with two reads in flight, 2-cycle memory
        do_reset();
        mem_req_accept = 1'b1;
        lat            = 2;
        repeat (4) tick();
        chk("t3_inflight_pre", 32'(inflight), 32'd2);
        chk("t3_occ_pre", 32'(occupancy), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        settle();
        chk("t3_no_req_in_redirect", 32'(mem_req_valid), 32'd0);
        tick();
        chk("t3_occ_flushed", 32'(occupancy), 32'd0);
        chk("t3_inflight_flushed", 32'(inflight), 32'd0);
        redirect_valid = 1'b0;
        issued.delete();
        push_exp(32'h100);
        push_exp(32'h104);
        push_exp(32'h108);
        dec_ready = 1'b1;
        tick();
        chk("t3_inflight_after_drop", 32'(inflight), 32'd1);
        chk("t3_occ_after_drop", 32'(occupancy), 32'd0);
        drain("t3_drain", 30);
        dec_ready = 1'b0;
        chk("t3_first_addr", issued[0], 32'h100);

        // 4: hold with two reads in flight
        do_reset();
        mem_req_accept = 1'b1;
        lat            = 2;
        dec_ready      = 1'b1;
        tick();
        tick();
        hold = 1'b1;
        settle();
        chk("t4_hold_req_valid", 32'(mem_req_valid), 32'd0);
        repeat (5) tick();
        chk("t4_occupancy", 32'(occupancy), 32'd2);
        chk("t4_inflight", 32'(inflight), 32'd0);
        chk("t4_dec_valid", 32'(dec_valid), 32'd0);
        chk("t4_issued_n", 32'(issued.size()), 32'd2);
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        hold = 1'b0;
        drain("t4_drain", 30);
        dec_ready = 1'b0;

        // 5: fetch address wraps from the high reset vector
        do_reset();
        tick();
        tick();
        chk("t5_dec_valid", 32'(h_dec_valid), 32'd1);
        chk("t5_dec_pc0", h_dec_pc, 32'hFFFF_FFF8);
        tick();
        chk("t5_dec_pc1", h_dec_pc, 32'hFFFF_FFFC);
        tick();
        chk("t5_dec_pc2", h_dec_pc, 32'h0000_0000);
        chk("t5_issued_n", 32'(h_issued.size() >= 3), 32'd1);
        chk("t5_issued0", h_issued[0], 32'hFFFF_FFF8);
        chk("t5_issued1", h_issued[1], 32'hFFFF_FFFC);
        chk("t5_issued2", h_issued[2], 32'h0000_0000);

        // 6: reset mid-operation
        do_reset();
        mem_req_accept = 1'b1;
        repeat (4) tick();
        chk("t6_occ_pre", 32'(occupancy), 32'd3);
        chk("t6_inflight_pre", 32'(inflight), 32'd1);
        rst = 1'b1;
        tick();
        settle();
        chk("t6_occupancy", 32'(occupancy), 32'd0);
        chk("t6_inflight", 32'(inflight), 32'd0);
        chk("t6_dec_valid", 32'(dec_valid), 32'd0);
        chk("t6_req_valid", 32'(mem_req_valid), 32'd0);
        chk("t6_req_addr", mem_req_addr, 32'h0);
        rst = 1'b0;
        clear_logs();
        settle();
        chk("t6_restart_valid", 32'(mem_req_valid), 32'd1);
        chk("t6_restart_addr", mem_req_addr, 32'h0);
        push_exp(32'h0);
        push_exp(32'h4);
        dec_ready = 1'b1;
        drain("t6_drain", 20);
        dec_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
